// File: rtl/mm_seq_ctrl.sv
// Address/strobe sequencer for a row-by-row matrix-vector multiply P = A*x.
// Optional macro MM_SEQ_CTRL_PIPE_EN adds a result_en/addr_P stage and a FLUSH state.
module mm_seq_ctrl #(
    parameter int ROWS   = 4,
    parameter int COLS   = 4,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              Start,
    output logic              result_en,
    output logic              control,
    output logic [ADDR_W-1:0] addr_x,
    output logic [ADDR_W-1:0] addr_A,
    output logic [ADDR_W-1:0] addr_P,
    output logic              busy,
    output logic              done
);

    localparam int IW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int JW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam logic [IW-1:0] I_LAST = IW'(ROWS - 1);
    localparam logic [JW-1:0] J_LAST = JW'(COLS - 1);

    if (ROWS < 1 || ROWS > 16 || COLS < 1 || COLS > 16) begin : g_bad_dims
        $error("mm_seq_ctrl: ROWS and COLS must be in 1..16");
    end
    if (ROWS * COLS > 2 ** ADDR_W) begin : g_bad_addr
        $error("mm_seq_ctrl: ROWS*COLS does not fit in ADDR_W bits");
    end

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FLUSH, S_DONE} state_t;

`ifdef MM_SEQ_CTRL_PIPE_EN
    localparam state_t S_AFTER_CALC = S_FLUSH;
`else
    localparam state_t S_AFTER_CALC = S_DONE;
`endif

    state_t            state_q, state_d;
    logic [IW-1:0]     i_q, i_d;
    logic [JW-1:0]     j_q, j_d;
    logic [ADDR_W-1:0] a_q, a_d;

    logic              res_q, res_d;
    logic              control_q, control_d;
    logic [ADDR_W-1:0] addr_x_q, addr_x_d;
    logic [ADDR_W-1:0] addr_a_q, addr_a_d;
    logic [ADDR_W-1:0] pidx_q, pidx_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    // State register; every output is a flop so it lines up with state_q.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            i_q       <= '0;
            j_q       <= '0;
            a_q       <= '0;
            res_q     <= 1'b0;
            control_q <= 1'b0;
            addr_x_q  <= '0;
            addr_a_q  <= '0;
            pidx_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            i_q       <= i_d;
            j_q       <= j_d;
            a_q       <= a_d;
            res_q     <= res_d;
            control_q <= control_d;
            addr_x_q  <= addr_x_d;
            addr_a_q  <= addr_a_d;
            pidx_q    <= pidx_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // Next state and counters; the linear A index is a running counter so it
    // never needs a multiplier and always equals i*COLS+j.
    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        a_d     = a_q;
        unique case (state_q)
            S_IDLE: begin
                if (Start) begin
                    state_d = S_CALC;
                    i_d     = '0;
                    j_d     = '0;
                    a_d     = '0;
                end
            end
            S_CALC: begin
                if (j_q == J_LAST) begin
                    if (i_q == I_LAST) begin
                        state_d = S_AFTER_CALC;
                    end else begin
                        i_d = i_q + 1'b1;
                        j_d = '0;
                        a_d = a_q + 1'b1;
                    end
                end else begin
                    j_d = j_q + 1'b1;
                    a_d = a_q + 1'b1;
                end
            end
            S_FLUSH: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output values for the cycle that state_d/i_d/j_d describe.
    always_comb begin
        control_d = 1'b0;
        addr_x_d  = '0;
        addr_a_d  = '0;
        res_d     = 1'b0;
        pidx_d    = pidx_q;
        busy_d    = (state_d == S_CALC) || (state_d == S_FLUSH);
        done_d    = (state_d == S_DONE);
        if (state_d == S_CALC) begin
            control_d = (j_d == '0);
            addr_x_d  = ADDR_W'(j_d);
            addr_a_d  = a_d;
            res_d     = (j_d == J_LAST);
            if (j_d == J_LAST) pidx_d = ADDR_W'(i_d);
        end
    end

`ifdef MM_SEQ_CTRL_PIPE_EN
    logic              res_p_q, res_p_d;
    logic [ADDR_W-1:0] addr_p_q, addr_p_d;

    always_comb begin
        res_p_d  = res_q;
        addr_p_d = res_q ? pidx_q : addr_p_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            res_p_q  <= 1'b0;
            addr_p_q <= '0;
        end else begin
            res_p_q  <= res_p_d;
            addr_p_q <= addr_p_d;
        end
    end

    assign result_en = res_p_q;
    assign addr_P    = addr_p_q;
`else
    assign result_en = res_q;
    assign addr_P    = pidx_q;
`endif

    assign control = control_q;
    assign addr_x  = addr_x_q;
    assign addr_A  = addr_a_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_mm_seq_ctrl.sv
// Directed bench for mm_seq_ctrl: default 4x4 instance plus a 3x1 instance.
module tb_mm_seq_ctrl;

`ifdef MM_SEQ_CTRL_PIPE_EN
    localparam int PD = 1;
`else
    localparam int PD = 0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       start2 = 1'b0;
    logic       res_en, control, busy, done;
    logic [3:0] addr_x, addr_a, addr_p;
    logic       res_en2, control2, busy2, done2;
    logic [1:0] addr_x2, addr_a2, addr_p2;

    int n_checks = 0;
    int n_fail   = 0;

    mm_seq_ctrl dut (
        .clk(clk), .rst(rst), .Start(start),
        .result_en(res_en), .control(control),
        .addr_x(addr_x), .addr_A(addr_a), .addr_P(addr_p),
        .busy(busy), .done(done)
    );

    mm_seq_ctrl #(.ROWS(3), .COLS(1), .ADDR_W(2)) dut2 (
        .clk(clk), .rst(rst), .Start(start2),
        .result_en(res_en2), .control(control2),
        .addr_x(addr_x2), .addr_A(addr_a2), .addr_P(addr_p2),
        .busy(busy2), .done(done2)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b1;
        start2 = 1'b1;
        repeat (5) tick();
        n_checks++;
        if ({res_en, control, addr_x, addr_a, addr_p, busy, done} !== 15'd0) begin
            n_fail++;
            $display("FAIL reset_dut1 got %b exp all zero",
                     {res_en, control, addr_x, addr_a, addr_p, busy, done});
        end
        n_checks++;
        if ({res_en2, control2, addr_x2, addr_a2, addr_p2, busy2, done2} !== 10'd0) begin
            n_fail++;
            $display("FAIL reset_dut2 got %b exp all zero",
                     {res_en2, control2, addr_x2, addr_a2, addr_p2, busy2, done2});
        end
        start = 1'b0;
        start2 = 1'b0;
        rst = 1'b0;
        tick();
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset busy got %b exp 0", busy);
        end
    endtask

    // Full default run; toggle=1 wiggles Start throughout CALC.
    task automatic test_default_run(input bit toggle);
        logic [3:0] ea, ex, ep;
        logic       ec, er;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 16; k++) begin
            ea = 4'(k);
            ex = 4'(k % 4);
            ec = (k % 4 == 0);
            er = (PD == 1) ? (k % 4 == 0 && k > 0) : (k % 4 == 3);
            ep = 4'(k / 4 - PD);
            n_checks++;
            if (busy !== 1'b1 || done !== 1'b0) begin
                n_fail++;
                $display("FAIL run busy/done k=%0d got %b%b exp 10", k, busy, done);
            end
            n_checks++;
            if (addr_a !== ea || addr_x !== ex || control !== ec) begin
                n_fail++;
                $display("FAIL run addr k=%0d got A=%0d x=%0d c=%b exp A=%0d x=%0d c=%b",
                         k, addr_a, addr_x, control, ea, ex, ec);
            end
            n_checks++;
            if (res_en !== er || (er && addr_p !== ep)) begin
                n_fail++;
                $display("FAIL run result k=%0d got en=%b P=%0d exp en=%b P=%0d",
                         k, res_en, addr_p, er, ep);
            end
            start = toggle && (k < 15) ? 1'(k % 2) : 1'b0;
            tick();
        end
`ifdef MM_SEQ_CTRL_PIPE_EN
        n_checks++;
        if (busy !== 1'b1 || res_en !== 1'b1 || addr_p !== 4'd3 || addr_a !== 4'd0 || control !== 1'b0) begin
            n_fail++;
            $display("FAIL flush got busy=%b en=%b P=%0d A=%0d c=%b exp 1 1 3 0 0",
                     busy, res_en, addr_p, addr_a, control);
        end
        tick();
`endif
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b0 || res_en !== 1'b0 || addr_a !== 4'd0 || addr_x !== 4'd0) begin
            n_fail++;
            $display("FAIL done_cycle got done=%b busy=%b en=%b A=%0d x=%0d exp 1 0 0 0 0",
                     done, busy, res_en, addr_a, addr_x);
        end
        tick();
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0 || addr_p !== 4'd3) begin
            n_fail++;
            $display("FAIL idle_after_run got done=%b busy=%b P=%0d exp 0 0 3", done, busy, addr_p);
        end
        tick();
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL stays_idle busy got %b exp 0", busy);
        end
    endtask

    task automatic test_cols1();
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (busy2 !== 1'b1 || control2 !== 1'b1 || addr_a2 !== 2'(k) || addr_x2 !== 2'd0) begin
                n_fail++;
                $display("FAIL cols1 addr k=%0d got busy=%b c=%b A=%0d x=%0d exp 1 1 %0d 0",
                         k, busy2, control2, addr_a2, addr_x2, k);
            end
            n_checks++;
            if (res_en2 !== (PD == 0 || k > 0) || (res_en2 === 1'b1 && addr_p2 !== 2'(k - PD))) begin
                n_fail++;
                $display("FAIL cols1 result k=%0d got en=%b P=%0d exp en=%b P=%0d",
                         k, res_en2, addr_p2, (PD == 0 || k > 0), k - PD);
            end
            tick();
        end
`ifdef MM_SEQ_CTRL_PIPE_EN
        n_checks++;
        if (res_en2 !== 1'b1 || addr_p2 !== 2'd2 || busy2 !== 1'b1) begin
            n_fail++;
            $display("FAIL cols1 flush got en=%b P=%0d busy=%b exp 1 2 1", res_en2, addr_p2, busy2);
        end
        tick();
`endif
        n_checks++;
        if (done2 !== 1'b1 || res_en2 !== 1'b0 || busy2 !== 1'b0 || addr_p2 !== 2'd2) begin
            n_fail++;
            $display("FAIL cols1 done got done=%b en=%b busy=%b P=%0d exp 1 0 0 2",
                     done2, res_en2, busy2, addr_p2);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        start = 1'b1;
        tick();
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 16 + PD; k++) begin
                n_checks++;
                if (busy !== 1'b1 || done !== 1'b0) begin
                    n_fail++;
                    $display("FAIL b2b busy r=%0d k=%0d got busy=%b done=%b exp 1 0", r, k, busy, done);
                end
                tick();
            end
            n_checks++;
            if (done !== 1'b1 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL b2b done r=%0d got done=%b busy=%b exp 1 0", r, done, busy);
            end
            tick();
            n_checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL b2b idle r=%0d got done=%b busy=%b exp 0 0", r, done, busy);
            end
            tick();
        end
        n_checks++;
        if (busy !== 1'b1 || addr_a !== 4'd0 || control !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b third_start got busy=%b A=%0d c=%b exp 1 0 1", busy, addr_a, control);
        end
        start = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        n_checks++;
        if (addr_a !== 4'd5 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst precondition got A=%0d busy=%b exp 5 1", addr_a, busy);
        end
        rst = 1'b1;
        start = 1'b1;
        tick();
        rst = 1'b0;
        start = 1'b0;
        n_checks++;
        if ({res_en, control, addr_x, addr_a, addr_p, busy, done} !== 15'd0) begin
            n_fail++;
            $display("FAIL midrst outputs got %b exp all zero",
                     {res_en, control, addr_x, addr_a, addr_p, busy, done});
        end
        for (int k = 0; k < 25; k++) begin
            tick();
            n_checks++;
            if (res_en !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL midrst quiet k=%0d got en=%b done=%b busy=%b exp 0 0 0",
                         k, res_en, done, busy);
            end
        end
    endtask

    initial begin
        test_reset();
        test_default_run(1'b0);
        test_default_run(1'b1);
        test_cols1();
        test_back_to_back();
        test_reset_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
